// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int unsigned DEF_MEM_LAT    = 2;
    localparam int unsigned DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data ports, with the fetch-starvation
// counter that forces fetch through after STARVE_MAX consecutive data wins.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic grant_i,
    output logic winner_o
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] r_starve_cnt;
    logic          w_winner;

    always_comb begin
        w_winner = PORT_IF;
        if (dm_req_i && (!if_req_i || (r_starve_cnt < SMAX))) begin
            w_winner = PORT_DM;
        end
    end

    // Only data wins that bypass a pending fetch count toward starvation.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_starve_cnt <= '0;
        end else if (grant_i) begin
            if (w_winner == PORT_IF) begin
                r_starve_cnt <= '0;
            end else if (if_req_i && (r_starve_cnt != SMAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign winner_o = w_winner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch
// (port 0) and the MEM-stage data port (port 1), one access at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_done_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_done_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          stall_if_o,
    output logic          stall_mem_o
);

    generate
        if (MEM_LAT < 1) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be at least 1");
        end
    endgenerate

    localparam int unsigned LW = $clog2(MEM_LAT + 1);

    state_t          r_state;
    state_t          w_next;
    logic [LW-1:0]   r_lat_cnt;
    logic            r_winner;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_dm_rdata;
    logic            w_grant;
    logic            w_pick;

    assign w_grant = (r_state == IDLE) && (if_req_i || dm_req_i);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .if_req_i (if_req_i),
        .dm_req_i (dm_req_i),
        .grant_i  (w_grant),
        .winner_o (w_pick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (if_req_i || dm_req_i) w_next = ACCESS;
            ACCESS:  if (r_lat_cnt == '0)      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Payload is captured at grant so requester changes mid-access are ignored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lat_cnt  <= '0;
            r_winner   <= PORT_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_grant) begin
            r_winner  <= w_pick;
            r_addr    <= (w_pick == PORT_DM) ? dm_addr_i : if_addr_i;
            r_we      <= (w_pick == PORT_DM) && dm_we_i;
            r_wdata   <= dm_wdata_i;
            r_lat_cnt <= LW'(MEM_LAT - 1);
        end else if (r_state == ACCESS) begin
            if (r_lat_cnt == '0) begin
                if (!r_we) begin
                    if (r_winner == PORT_IF) begin
                        r_if_rdata <= mem_rdata_i;
                    end else begin
                        r_dm_rdata <= mem_rdata_i;
                    end
                end
            end else begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    assign mem_en_o    = (r_state == ACCESS);
    assign mem_we_o    = (r_state == ACCESS) && r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    assign if_done_o   = (r_state == DONE) && (r_winner == PORT_IF);
    assign dm_done_o   = (r_state == DONE) && (r_winner == PORT_DM);
    assign if_rdata_o  = r_if_rdata;
    assign dm_rdata_o  = r_dm_rdata;

    assign stall_if_o  = if_req_i && !if_done_o;
    assign stall_mem_o = dm_req_i && !dm_done_o;

endmodule
